// File: rtl/instr_decoder_irq.sv
// ---------------------------------------------------------------------------
// instr_decoder_irq
//
// Purpose:
//   Instruction register plus combinational decoder for the 8-bit datapath.
//   It sits between program memory and the datapath/ALU. It also contains a
//   small interrupt engine: a run of TRIG_COUNT consecutive TRIG_OP
//   instructions raises an interrupt request. The request is retired by
//   int_ack, and service ends when RETI_OP reaches the instruction register.
//
// Parameters:
//   TRIG_OP    opcode whose consecutive occurrences raise an interrupt
//   TRIG_COUNT number of consecutive TRIG_OP needed (>= 1)
//   RETI_OP    opcode that ends interrupt service
//   RESET_IR   value loaded into ir on reset (a NOP)
//
// Ports:
//   clk         in   rising-edge clock
//   sync_reset  in   asynchronous, active-high reset
//   next_instr  in   [7:0] instruction from program memory
//   stall       in   hold ir and insert a decode bubble
//   int_ack     in   interrupt acknowledge from the controller
//   ir          out  [7:0] instruction register
//   ir_nibble   out  [3:0] ir[3:0]
//   reg_en      out  [8:0] enables x0,x1,y0,y1,r,m,i,dm,o_reg (bits 0..8)
//   source_sel  out  [3:0] data-bus source select
//   i_sel       out  I operand select
//   x_sel       out  X operand select
//   y_sel       out  Y operand select
//   jmp         out  unconditional jump
//   jmp_nz      out  jump if not zero
//   int_req     out  registered interrupt request (high in PEND)
//   int_busy    out  registered, high in SERVICE
//   int_state   out  [1:0] FSM state: 0 IDLE, 1 PEND, 2 SERVICE
//   run_cnt     out  current trigger run count
//
// Handshake:
//   int_req is a level request. It rises the cycle after the last TRIG_OP of
//   a run occupies ir, and it stays high until int_ack is seen high at a
//   rising edge. At that same edge int_req falls and int_busy rises, and
//   both changes are visible from the next cycle. int_ack is only honoured
//   while a request is pending, and it is honoured even in stalled cycles.
//   int_busy stays high until RETI_OP occupies ir in a non-stalled cycle.
// ---------------------------------------------------------------------------
module instr_decoder_irq #(
    parameter logic [7:0]  TRIG_OP    = 8'hC8,
    parameter int unsigned TRIG_COUNT = 3,
    parameter logic [7:0]  RETI_OP    = 8'hDF,
    parameter logic [7:0]  RESET_IR   = 8'hCF,
    localparam int unsigned CNT_W     = $clog2(TRIG_COUNT + 1)
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       next_instr,
    input  logic             stall,
    input  logic             int_ack,
    output logic [7:0]       ir,
    output logic [3:0]       ir_nibble,
    output logic [8:0]       reg_en,
    output logic [3:0]       source_sel,
    output logic             i_sel,
    output logic             x_sel,
    output logic             y_sel,
    output logic             jmp,
    output logic             jmp_nz,
    output logic             int_req,
    output logic             int_busy,
    output logic [1:0]       int_state,
    output logic [CNT_W-1:0] run_cnt
);

    // Register-enable bit positions
    localparam int unsigned EN_X0  = 0;
    localparam int unsigned EN_X1  = 1;
    localparam int unsigned EN_Y0  = 2;
    localparam int unsigned EN_Y1  = 3;
    localparam int unsigned EN_R   = 4;
    localparam int unsigned EN_M   = 5;
    localparam int unsigned EN_I   = 6;
    localparam int unsigned EN_DM  = 7;
    localparam int unsigned EN_OUT = 8;

    // Source-select codes that are not taken straight from ir[2:0]
    localparam logic [3:0] SRC_IMM    = 4'd8;   // immediate / load
    localparam logic [3:0] SRC_SELF   = 4'd9;   // move onto itself
    localparam logic [3:0] SRC_RESET  = 4'd10;  // driven while in reset

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TRIG_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PEND    = 2'd1,
        S_SERVICE = 2'd2,
        S_BAD     = 2'd3
    } irq_state_t;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [7:0]       ir_q;
    irq_state_t       state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             int_req_q, int_req_d;
    logic             int_busy_q, int_busy_d;

    // Decoder intermediates (before stall/reset gating)
    logic [8:0]       dec_reg_en;
    logic [3:0]       dec_source_sel;
    logic             dec_jmp;
    logic             dec_jmp_nz;
    logic             dec_i_sel;

    // Maps a 3-bit destination field to its register enable(s).
    // Code 7 writes the data memory and also updates the index register.
    function automatic logic [8:0] dest_enable(input logic [2:0] dest);
        logic [8:0] en;
        en = '0;
        case (dest)
            3'd0: en[EN_X0]  = 1'b1;
            3'd1: en[EN_X1]  = 1'b1;
            3'd2: en[EN_Y0]  = 1'b1;
            3'd3: en[EN_Y1]  = 1'b1;
            3'd4: en[EN_OUT] = 1'b1;
            3'd5: en[EN_M]   = 1'b1;
            3'd6: en[EN_I]   = 1'b1;
            default: begin
                en[EN_DM] = 1'b1;
                en[EN_I]  = 1'b1;
            end
        endcase
        return en;
    endfunction

    // -----------------------------------------------------------------------
    // Instruction register: holds its value during a stall.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            ir_q <= RESET_IR;
        end else if (!stall) begin
            ir_q <= next_instr;
        end
    end

    // -----------------------------------------------------------------------
    // Decoder (purely a function of ir_q)
    // -----------------------------------------------------------------------
    always_comb begin
        dec_reg_en     = '0;
        dec_source_sel = '0;
        if (!ir_q[7]) begin
            // Load immediate
            dec_reg_en     = dest_enable(ir_q[6:4]);
            dec_source_sel = SRC_IMM;
        end else if (ir_q[7:6] == 2'b10) begin
            // Register move. Source 7 (data memory) post-updates the index.
            dec_reg_en = dest_enable(ir_q[5:3]);
            if (ir_q[2:0] == 3'd7) begin
                dec_reg_en[EN_I] = 1'b1;
            end
            // A move onto itself selects a special source, except for the
            // output register, which keeps its plain source code 4.
            if (ir_q[5:3] == ir_q[2:0]) begin
                dec_source_sel = (ir_q[2:0] == 3'd4) ? 4'd4 : SRC_SELF;
            end else begin
                dec_source_sel = {1'b0, ir_q[2:0]};
            end
        end else if (ir_q[7:5] == 3'b110) begin
            // ALU operation: the result goes to r
            dec_reg_en[EN_R] = 1'b1;
            dec_source_sel   = {1'b0, ir_q[2:0]};
        end
    end

    assign dec_jmp    = (ir_q[7:4] == 4'b1110);
    assign dec_jmp_nz = (ir_q[7:4] == 4'b1111);
    assign dec_i_sel  = !((ir_q[7:4] == 4'b0110) || (ir_q[7:3] == 5'b10110));

    // Output gating. Reset forces a known, safe bus. A stall suppresses every
    // side effect (writes and jumps) but leaves the operand selects alone.
    always_comb begin
        reg_en     = dec_reg_en;
        source_sel = dec_source_sel;
        jmp        = dec_jmp;
        jmp_nz     = dec_jmp_nz;
        i_sel      = dec_i_sel;
        x_sel      = ir_q[4];
        y_sel      = ir_q[3];
        if (sync_reset) begin
            reg_en     = 9'h1FF;
            source_sel = SRC_RESET;
            jmp        = 1'b0;
            jmp_nz     = 1'b0;
            i_sel      = 1'b0;
            x_sel      = 1'b0;
            y_sel      = 1'b0;
        end else if (stall) begin
            reg_en = '0;
            jmp    = 1'b0;
            jmp_nz = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_q    <= S_IDLE;
            run_cnt_q  <= '0;
            int_req_q  <= 1'b0;
            int_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            int_req_q  <= int_req_d;
            int_busy_q <= int_busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt FSM: next state
    // -----------------------------------------------------------------------
    // The FSM looks at ir_q, which is the instruction currently being
    // decoded. A stalled cycle repeats the same ir_q, so it must not count
    // again. The acknowledge is the only exception, because the controller
    // may answer while the pipeline is frozen.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!stall) begin
                    if (ir_q == TRIG_OP) begin
                        if (run_cnt_q == RUN_LAST) begin
                            run_cnt_d = '0;
                            state_d   = S_PEND;
                        end else begin
                            run_cnt_d = run_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end
            end
            S_PEND: begin
                run_cnt_d = '0;
                if (int_ack) begin
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                // A TRIG_OP seen here, even in the same cycle as RETI_OP,
                // does not start a new run.
                run_cnt_d = '0;
                if (!stall && (ir_q == RETI_OP)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                run_cnt_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Interrupt FSM: outputs
    // -----------------------------------------------------------------------
    // The request and busy flags are taken from the next state, so the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        int_req_d  = (state_d == S_PEND);
        int_busy_d = (state_d == S_SERVICE);
    end

    assign ir        = ir_q;
    assign ir_nibble = ir_q[3:0];
    assign int_req   = int_req_q;
    assign int_busy  = int_busy_q;
    assign int_state = state_q;
    assign run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_instr_decoder_irq.sv
module tb_instr_decoder_irq;

  localparam logic [7:0] TRIG   = 8'hC8;
  localparam logic [7:0] RETI   = 8'hDF;
  localparam logic [7:0] RST_IR = 8'hCF;
  localparam int         TCOUNT = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] next_instr;
  logic       stall;
  logic       int_ack;
  logic [7:0] ir;
  logic [3:0] ir_nibble;
  logic [8:0] reg_en;
  logic [3:0] source_sel;
  logic       i_sel, x_sel, y_sel, jmp, jmp_nz;
  logic       int_req, int_busy;
  logic [1:0] int_state;
  logic [1:0] run_cnt;

  always #5 clk = ~clk;

  instr_decoder_irq #(
    .TRIG_OP   (TRIG),
    .TRIG_COUNT(TCOUNT),
    .RETI_OP   (RETI),
    .RESET_IR  (RST_IR)
  ) dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .next_instr(next_instr),
    .stall     (stall),
    .int_ack   (int_ack),
    .ir        (ir),
    .ir_nibble (ir_nibble),
    .reg_en    (reg_en),
    .source_sel(source_sel),
    .i_sel     (i_sel),
    .x_sel     (x_sel),
    .y_sel     (y_sel),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .int_req   (int_req),
    .int_busy  (int_busy),
    .int_state (int_state),
    .run_cnt   (run_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];      // instructions accepted, waiting to appear in ir
  logic [7:0] m_ir;          // instruction the model believes is in ir
  bit         m_pending;     // interrupt raised, not yet acknowledged
  bit         m_serving;     // interrupt acknowledged, RETI not yet seen
  int         m_run;         // TRIG_OP seen back-to-back so far

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register enables selected by a 3-bit destination code
  function automatic logic [8:0] dest_bits(input int f);
    if (f == 4) return 9'h100;        // o_reg
    if (f == 7) return 9'h0C0;        // dm plus i
    return 9'(1 << f);
  endfunction

  // Compare every output against what the decode rules and the model state say
  task automatic check_all();
    logic [8:0] e_re;
    int         e_ss;
    bit         chk_ss;
    bit         e_jmp, e_jnz, e_isel;
    int         e_state;
    chk_ss = 1;
    e_ss   = 0;
    if (m_ir < 8'h80) begin
      e_re = dest_bits(int'(m_ir[6:4]));
      e_ss = 8;
    end else if (m_ir < 8'hC0) begin
      e_re = dest_bits(int'(m_ir[5:3])) | ((m_ir[2:0] == 3'd7) ? 9'h040 : 9'h000);
      if (m_ir[5:3] == m_ir[2:0]) e_ss = (m_ir[2:0] == 3'd4) ? 4 : 9;
      else                        e_ss = int'(m_ir[2:0]);
    end else if (m_ir < 8'hE0) begin
      e_re = 9'h010;
      e_ss = int'(m_ir[2:0]);
    end else begin
      e_re   = 9'h000;
      chk_ss = 0;                     // jumps leave the source bus undefined
    end
    e_jmp  = ((m_ir >> 4) == 8'd14);
    e_jnz  = ((m_ir >> 4) == 8'd15);
    e_isel = !(((m_ir >> 4) == 8'd6) || ((m_ir >> 3) == 8'd22));
    if (stall) begin
      e_re  = 9'h000;
      e_jmp = 1'b0;
      e_jnz = 1'b0;
    end
    e_state = m_serving ? 2 : (m_pending ? 1 : 0);

    check("ir",         ir,         m_ir);
    check("ir_nibble",  ir_nibble,  m_ir & 8'h0F);
    check("reg_en",     reg_en,     e_re);
    if (chk_ss) check("source_sel", source_sel, e_ss);
    check("jmp",        jmp,        e_jmp);
    check("jmp_nz",     jmp_nz,     e_jnz);
    check("i_sel",      i_sel,      e_isel);
    check("x_sel",      x_sel,      (m_ir >> 4) & 8'h1);
    check("y_sel",      y_sel,      (m_ir >> 3) & 8'h1);
    check("int_req",    int_req,    m_pending);
    check("int_busy",   int_busy,   m_serving);
    check("int_state",  int_state,  e_state);
    check("run_cnt",    run_cnt,    m_run);
  endtask

  task automatic check_reset();
    check("rst_ir",         ir,         8'hCF);
    check("rst_ir_nibble",  ir_nibble,  4'hF);
    check("rst_reg_en",     reg_en,     9'h1FF);
    check("rst_source_sel", source_sel, 10);
    check("rst_jmp",        jmp,        0);
    check("rst_jmp_nz",     jmp_nz,     0);
    check("rst_i_sel",      i_sel,      0);
    check("rst_x_sel",      x_sel,      0);
    check("rst_y_sel",      y_sel,      0);
    check("rst_int_req",    int_req,    0);
    check("rst_int_busy",   int_busy,   0);
    check("rst_int_state",  int_state,  0);
    check("rst_run_cnt",    run_cnt,    0);
  endtask

  // Advance the model across one rising edge, using the pre-edge inputs
  task automatic model_update(input logic [7:0] instr, input bit st, input bit ack);
    if (m_pending && ack) begin
      m_pending = 0;
      m_serving = 1;
      m_run     = 0;
    end else if (!st) begin
      if (m_serving) begin
        if (m_ir == RETI) m_serving = 0;
      end else if (!m_pending) begin
        if (m_ir == TRIG) begin
          m_run++;
          if (m_run == TCOUNT) begin
            m_run     = 0;
            m_pending = 1;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    if (!st) exp_q.push_back(instr);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drive, check the combinational view, clock, update model
  task automatic drive_cycle(input logic [7:0] instr, input bit st, input bit ack);
    next_instr = instr;
    stall      = st;
    int_ack    = ack;
    #1;
    check_all();
    @(posedge clk);
    model_update(instr, st, ack);
    #1;
    if (exp_q.size() > 0) m_ir = exp_q.pop_front();
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    stall      = 1'b0;
    int_ack    = 1'b0;
    #1;
    check_reset();                    // asynchronous: visible before any edge
    m_ir      = RST_IR;
    m_pending = 0;
    m_serving = 0;
    m_run     = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_reset();
    sync_reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sync_reset = 1'b1;
    next_instr = 8'h00;
    stall      = 1'b0;
    int_ack    = 1'b0;
    #1;
    do_reset();

    // decode: load, moves, ALU, jumps, i_sel exceptions
    drive_cycle(8'h25, 0, 0);
    drive_cycle(8'h9C, 0, 0);
    drive_cycle(8'hA4, 0, 0);
    drive_cycle(8'hC3, 0, 0);
    drive_cycle(8'hE5, 0, 0);
    drive_cycle(8'hF3, 0, 0);
    drive_cycle(8'h8F, 1, 0);         // stall with a jump in ir
    drive_cycle(8'h8F, 0, 0);
    drive_cycle(8'h92, 0, 0);
    drive_cycle(8'hB5, 0, 0);
    drive_cycle(8'h65, 0, 0);
    drive_cycle(8'h00, 0, 0);

    // three triggers -> request, acknowledge, triggers ignored, return
    repeat (3) drive_cycle(TRIG, 0, 0);
    repeat (2) drive_cycle(8'h00, 0, 0);
    drive_cycle(8'h00, 0, 1);
    repeat (3) drive_cycle(TRIG, 0, 0);
    drive_cycle(RETI, 0, 0);
    repeat (2) drive_cycle(8'h00, 0, 0);

    // broken run: no request
    drive_cycle(TRIG, 0, 0);
    drive_cycle(TRIG, 0, 0);
    drive_cycle(8'h00, 0, 0);
    drive_cycle(TRIG, 0, 0);
    repeat (2) drive_cycle(8'h00, 0, 0);

    // stall inside a run does not break it; acknowledge during a stall
    drive_cycle(TRIG, 0, 0);
    drive_cycle(TRIG, 0, 0);
    drive_cycle(8'h11, 1, 0);
    drive_cycle(8'h11, 1, 0);
    drive_cycle(TRIG, 0, 0);
    repeat (2) drive_cycle(8'h00, 0, 0);
    drive_cycle(8'h00, 1, 1);
    drive_cycle(RETI, 0, 0);
    repeat (2) drive_cycle(8'h00, 0, 0);

    // acknowledge in IDLE is ignored
    repeat (2) drive_cycle(8'h00, 0, 1);
    repeat (2) drive_cycle(TRIG, 0, 1);
    repeat (2) drive_cycle(8'h00, 0, 0);

    // reset during SERVICE
    repeat (3) drive_cycle(TRIG, 0, 0);
    drive_cycle(8'h00, 0, 0);
    drive_cycle(8'h00, 0, 1);
    drive_cycle(8'h00, 0, 0);
    do_reset();

    // randomized traffic biased towards trigger/return opcodes
    for (int n = 0; n < 400; n++) begin
      logic [7:0] instr;
      int         pick;
      pick = $urandom_range(0, 9);
      if (pick < 4)       instr = TRIG;
      else if (pick == 4) instr = RETI;
      else                instr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive_cycle(instr, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    #1;
    check_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decoder_irq.md
# instr_decoder_irq

Parametrised successor to the 8-bit instruction decoder: registers the fetched instruction, decodes register enables, source select, X/Y/I selects and jumps, and adds a pipeline stall and a NOP-sequence interrupt engine with a request/acknowledge handshake and a return opcode. It sits between program memory and the datapath/ALU. The trigger opcode, trigger run length and return opcode are parameters.

## Interface
- TRIG_OP, 8'hC8, opcode whose consecutive occurrences raise an interrupt
- TRIG_COUNT, 3, consecutive TRIG_OP instructions required (≥1)
- RETI_OP, 8'hDF, opcode that ends interrupt service
- RESET_IR, 8'hCF, value loaded into ir on reset (a NOP)
- clk  in  1  clock, rising edge
- sync_reset  in  1  asynchronous, active-high reset
- next_instr  in  8  instruction from program memory
- stall  in  1  hold ir, insert decode bubble
- int_ack  in  1  interrupt acknowledge from controller
- ir  out  8  instruction register
- ir_nibble  out  4  ir[3:0]
- reg_en  out  9  enables x0,x1,y0,y1,r,m,i,dm,o_reg (bits 0..8)
- source_sel  out  4  data-bus source
- i_sel, x_sel, y_sel  out  1 each  operand selects
- jmp, jmp_nz  out  1 each  unconditional / not-zero jump
- int_req  out  1  registered interrupt request
- int_busy  out  1  registered, high in SERVICE
- int_state  out  2  FSM state: 0 IDLE, 1 PEND, 2 SERVICE
- run_cnt  out  $clog2(TRIG_COUNT+1)  current trigger run count

## Operation
- ir: posedge load of next_instr when stall=0; held when stall=1; RESET_IR on reset.
- Decode (combinational from ir, stall=0, reset low):
  - ir[7]=0 load: reg_en by ir[6:4] (0 x0,1 x1,2 y0,3 y1,4 o_reg,5 m,6 i,7 dm+i); source_sel=8.
  - ir[7:6]=10 move: dest ir[5:3] same map; source_sel=4 if ir[5:3]=ir[2:0]=4, =9 if ir[5:3]=ir[2:0] otherwise, else {0,ir[2:0]}; reg_en[6] also set when ir[2:0]=7.
  - ir[7:5]=110 ALU: reg_en[4]=1; source_sel={0,ir[2:0]}.
  - jmp = ir[7:4]=1110; jmp_nz = ir[7:4]=1111.
  - i_sel=0 for ir[7:4]=0110 or ir[7:3]=10110, else 1; x_sel=ir[4]; y_sel=ir[3].
- stall=1: reg_en=0, jmp=jmp_nz=0; other decode outputs follow ir.
- Reset asserted: reg_en=9'h1FF, source_sel=10, jmp=jmp_nz=i_sel=x_sel=y_sel=0.
- FSM, evaluated only on cycles with stall=0 (stalled cycles freeze run_cnt and state, except int_ack handling in PEND):
  - IDLE: ir==TRIG_OP → if run_cnt==TRIG_COUNT-1 then run_cnt←0, state←PEND, int_req←1; else run_cnt+1. ir≠TRIG_OP → run_cnt←0.
  - PEND: int_req held 1; int_ack=1 (sampled regardless of stall) → SERVICE, int_req←0, int_busy←1. TRIG_OP/RETI_OP ignored.
  - SERVICE: run_cnt held 0; ir==RETI_OP → IDLE, int_busy←0.
  - State encoding 3 unreachable; recovers to IDLE next edge.
- int_ack in IDLE or SERVICE ignored.

## Timing
- Reset values: ir=RESET_IR, run_cnt=0, int_state=0, int_req=0, int_busy=0; apply immediately (async), release synchronous to clk.
- ir→decode outputs: zero-cycle combinational.
- int_req rises the cycle after the TRIG_COUNT-th consecutive TRIG_OP occupies ir (non-stalled).
- int_ack sampled at the posedge; int_req falls and int_busy rises the next cycle.
- RETI_OP in ir during SERVICE: int_busy falls next cycle; a TRIG_OP in that same cycle is not counted.
- Reset mid-PEND/SERVICE: returns to IDLE, int_req=int_busy=0 at once.

## Test plan
- Reset pulse mid-run → ir=8'hCF, reg_en=9'h1FF, source_sel=10, int_req=0, int_state=0 asynchronously.
- Load 8'h25, move 8'h9C, move 8'hA4, ALU 8'hC3 → reg_en 9'h004/source_sel 8; 9'h008/source_sel 4; 9'h100/source_sel 4; 9'h010/source_sel 3.
- ir=C8,C8,C8 → int_req=1 cycle 4, int_state=1; sequence C8,C8,00,C8 → int_req stays 0, run_cnt 1,2,0,1.
- C8,C8, stall for 2 cycles, C8 → int_req rises after third non-stalled C8; reg_en=0, jmp=0 during stall.
- PEND + int_ack=1 → int_busy=1, int_req=0 next cycle; C8×3 in SERVICE → no new request; DF → int_busy=0, state IDLE.
- int_ack held high in IDLE → no effect; reset during SERVICE → int_busy=0, state IDLE immediately.
